// File: rtl/shift_n_sequencer.sv
// Multicycle shifter: picks the shift amount from one of N_SRC source words, captures it with the operand,
// then shifts up to STEP bits per cycle; start/done handshake, busy while shifting, done pulses in FINISH.
module shift_n_sequencer #(
  parameter int DATA_W  = 32,
  parameter int N_SRC   = 4,
  parameter int SEL_W   = 2,
  parameter int SHAMT_W = $clog2(DATA_W),
  parameter int STEP    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2:0]              shift_op,
  input  logic [SEL_W-1:0]        n_sel,
  input  logic [N_SRC*DATA_W-1:0] n_src,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out,
  output logic [SHAMT_W-1:0]      n_latched,
  output logic                    busy,
  output logic                    done
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SHAMT_W-1:0] n_q, n_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [2:0]         op_q, op_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] n_amt;
  logic [2:0]         op_norm;
  logic [SHAMT_W-1:0] k_amt;
  logic [SHAMT_W:0]   k_inv;
  logic [DATA_W-1:0]  shifted;
  logic               unused_src;

  // Only the low SHAMT_W bits of each source word carry the amount.
  assign unused_src = ^n_src;

  always_comb begin
    n_amt = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (n_sel == SEL_W'(k)) n_amt = n_src[k*DATA_W +: SHAMT_W];
    end
  end

  assign op_norm = (shift_op > OP_ROR) ? OP_NOP : shift_op;

  always_comb begin
    if ((SHAMT_W+1)'(STEP) >= {1'b0, rem_q}) k_amt = rem_q;
    else                                     k_amt = SHAMT_W'(STEP);
  end

  assign k_inv = (SHAMT_W+1)'(DATA_W) - {1'b0, k_amt};

  always_comb begin
    case (op_q)
      OP_SLL:  shifted = data_q << k_amt;
      OP_SRL:  shifted = data_q >> k_amt;
      OP_SRA:  shifted = $signed(data_q) >>> k_amt;
      OP_ROL:  shifted = (data_q << k_amt) | (data_q >> k_inv);
      OP_ROR:  shifted = (data_q >> k_amt) | (data_q << k_inv);
      default: shifted = data_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      n_q     <= '0;
      rem_q   <= '0;
      op_q    <= OP_NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    n_d     = n_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = data_in;
          n_d     = n_amt;
          rem_d   = n_amt;
          op_d    = op_norm;
          state_d = (n_amt == '0 || op_norm == OP_NOP) ? S_FINISH : S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - k_amt;
        if (rem_q == k_amt) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Flags are registered from the next state so they line up with the state they describe.
  always_comb begin
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_FINISH);
  end

  assign data_out  = data_q;
  assign n_latched = n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
